fetch_queue: RTL and testbench

Instruction fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word fetches to instruction memory over a request/response handshake. Returned instructions and their PCs are buffered in a small in-order prefetch FIFO, which is drained by the decode stage under backpressure. A redirect from EX (jump, jr, jal or a taken branch) flushes the FIFO and restarts fetch at the target.

---
 rtl/fetch_queue.sv | 147 ++++++++++++++
 tb/tb_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues word fetches over a
// req/ready + rvalid handshake with one request in flight, and buffers the
// returned {pc, instr} pairs in a small in-order prefetch FIFO drained by
// decode. A redirect from EX flushes the FIFO, marks any in-flight response
// as stale, and restarts fetch at redirect_pc.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Architectural state
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             drop_q, drop_d;
  logic [31:0]      mem_pc_q    [DEPTH];
  logic [31:0]      mem_pc_d    [DEPTH];
  logic [31:0]      mem_instr_q [DEPTH];
  logic [31:0]      mem_instr_d [DEPTH];

  // Handshake qualifiers
  logic [CNT_W-1:0] credit_used;
  logic             has_credit;
  logic             accept;
  logic             resp;
  logic             push;
  logic             pop;

  // Request issue, head-of-queue outputs and the per-cycle events they imply.
  // The credit check counts the in-flight request but not a same-cycle pop,
  // so a push can never land on a full FIFO.
  always_comb begin
    credit_used = count_q + CNT_W'(pend_q);
    has_credit  = (credit_used < FULL);
    imem_req    = !rst && !redirect && (!pend_q || imem_rvalid) && has_credit;
    imem_addr   = fetch_pc_q;
    out_valid   = !rst && (count_q != '0);
    out_pc      = rst ? 32'h0 : mem_pc_q[rd_ptr_q];
    out_instr   = rst ? 32'h0 : mem_instr_q[rd_ptr_q];
    accept      = imem_req && imem_ready;
    resp        = imem_rvalid && pend_q;
    push        = resp && !drop_q && !redirect;
    pop         = out_valid && out_ready && !redirect;
  end

  // Next-state: redirect overrides push, pop and issue; otherwise track the
  // in-flight request, retire stale responses and move the FIFO pointers.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    drop_d      = drop_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      // A response still outstanding belongs to the old path: keep waiting
      // for it but throw it away. One arriving right now is simply consumed.
      pend_d     = pend_q && !imem_rvalid;
      drop_d     = pend_q && !imem_rvalid;
    end else begin
      if (accept) begin
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else if (resp) begin
        pend_d = 1'b0;
      end

      if (resp && drop_q) begin
        drop_d = 1'b0;
      end

      if (push) begin
        mem_pc_d[wr_ptr_q]    = pend_pc_q;
        mem_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset; storage is cleared as well so the
  // head outputs are deterministic after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
      drop_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= 32'h0;
        mem_instr_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      drop_q      <= drop_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a behavioural instruction memory plus a queue-based
// reference model of the fetch front end, driven by directed and random knobs.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch PC, one in-flight request, a plain queue of entries.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } req_t;
  ent_t        m_q[$];
  logic [31:0] m_fpc = RESET_PC;
  logic        m_pend = 1'b0;
  logic [31:0] m_ppc = 32'h0;
  logic        m_drop = 1'b0;
  logic        m_known = 1'b0;

  // Instruction memory: outstanding accepted requests with a due cycle.
  req_t mem_q[$];
  logic mem_deliver;
  int   cyc = 0;

  // Stimulus knobs (percentages and latency)
  int          p_rst = 100, p_redir = 0, p_ready = 100, p_oready = 100, p_spur = 0;
  int          lat_min = 1, lat_extra = 0;
  logic        fixed_rpc = 1'b0;
  logic [31:0] rpc_val = 32'h0;

  logic e_req, e_valid;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  function automatic logic roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic begin_cycle();
    logic [31:0] r;
    @(negedge clk);
    rst       = roll(p_rst);
    redirect  = roll(p_redir);
    r         = $urandom;
    if (fixed_rpc) redirect_pc = rpc_val;
    else begin
      case (r[1:0])
        2'd0:    redirect_pc = {r[31:2], 2'b00};
        2'd1:    redirect_pc = 32'hFFFF_FFF8;
        default: redirect_pc = {24'h0, r[9:4], 2'b00};
      endcase
    end
    out_ready  = roll(p_oready);
    imem_ready = roll(p_ready);
    mem_deliver = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    if (mem_deliver) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(mem_q[0].addr);
    end else begin
      imem_rvalid = (mem_q.size() == 0) && roll(p_spur);
      imem_rdata  = $urandom;
    end
    #1;
    e_req   = !rst && !redirect && (!m_pend || imem_rvalid) &&
              (m_q.size() + int'(m_pend) < DEPTH);
    e_valid = !rst && (m_q.size() != 0);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (m_known) chk("imem_addr", imem_addr, m_fpc);
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    if (rst) begin
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
    end else if (e_valid) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
    end
  endtask

  task automatic end_cycle();
    logic acc, resp, pop;
    @(posedge clk);
    acc  = e_req && imem_ready;
    resp = imem_rvalid && m_pend;
    pop  = e_valid && out_ready;
    if (mem_deliver) void'(mem_q.pop_front());
    if (rst) begin
      mem_q.delete();
      m_q.delete();
      m_fpc   = RESET_PC;
      m_pend  = 1'b0;
      m_drop  = 1'b0;
      m_known = 1'b1;
    end else if (redirect) begin
      m_q.delete();
      m_fpc = redirect_pc;
      if (m_pend && !imem_rvalid) m_drop = 1'b1;
      else begin
        m_pend = 1'b0;
        m_drop = 1'b0;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (resp) begin
        if (m_drop) m_drop = 1'b0;
        else m_q.push_back('{pc: m_ppc, instr: imem_rdata});
        m_pend = 1'b0;
      end
      if (acc) begin
        mem_q.push_back('{addr: m_fpc, due: cyc + lat_min + int'($urandom_range(lat_extra))});
        m_pend = 1'b1;
        m_ppc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic quiet_knobs();
    p_rst = 0; p_redir = 0; p_ready = 100; p_oready = 100; p_spur = 0;
    lat_min = 1; lat_extra = 0; fixed_rpc = 1'b0;
  endtask

  task automatic do_reset(input int n);
    p_rst = 100;
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      end_cycle();
    end
    p_rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_n;
    logic [31:0] hold_addr;
    logic        seen;

    // Reset then stream with single-cycle memory and no backpressure
    quiet_knobs();
    do_reset(2);
    for (int k = 0; k < 12; k++) begin
      begin_cycle();
      if (k < 2) chk("stream_early_valid", 32'(out_valid), 32'h0);
      else begin
        chk("stream_valid", 32'(out_valid), 32'h1);
        chk("stream_pc", out_pc, 32'(4 * (k - 2)));
        chk("stream_instr", out_instr, 32'(4 * (k - 2)) + 32'h100);
      end
      end_cycle();
    end

    // Backpressure: fill the queue, then drain in order
    quiet_knobs();
    do_reset(1);
    p_oready = 0;
    for (int k = 0; k < 10; k++) begin
      begin_cycle();
      if (k == 9) begin
        chk("bp_req", 32'(imem_req), 32'h0);
        chk("bp_addr", imem_addr, 32'h10);
        chk("bp_head_pc", out_pc, 32'h0);
        chk("bp_valid", 32'(out_valid), 32'h1);
      end
      end_cycle();
    end
    p_oready = 100;
    exp_n = 32'h0;
    for (int k = 0; k < 14; k++) begin
      begin_cycle();
      if (out_valid) begin
        chk("drain_pc", out_pc, exp_n);
        exp_n = exp_n + 32'd4;
      end
      end_cycle();
    end

    // Stalled memory with spurious rvalid while nothing is in flight
    quiet_knobs();
    do_reset(1);
    p_ready = 0;
    p_spur  = 100;
    for (int k = 0; k < 5; k++) begin
      begin_cycle();
      chk("stall_req", 32'(imem_req), 32'h1);
      chk("stall_addr", imem_addr, RESET_PC);
      chk("stall_valid", 32'(out_valid), 32'h0);
      end_cycle();
    end

    // Redirect while a slow response is in flight
    quiet_knobs();
    do_reset(1);
    lat_min   = 3;
    fixed_rpc = 1'b1;
    rpc_val   = 32'h40;
    seen      = 1'b0;
    for (int k = 0; k < 30; k++) begin
      p_redir = (k == 7) ? 100 : 0;
      begin_cycle();
      if (k > 7 && out_valid && !seen) begin
        seen = 1'b1;
        chk("redir_first_pc", out_pc, 32'h40);
        chk("redir_first_instr", out_instr, 32'h140);
      end
      end_cycle();
    end
    chk("redir_seen", 32'(seen), 32'h1);

    // Reset mid-operation followed by a stray response
    quiet_knobs();
    p_oready = 30;
    lat_extra = 2;
    run(20);
    do_reset(1);
    p_ready = 0;
    p_spur  = 100;
    begin_cycle();
    chk("post_rst_req", 32'(imem_req), 32'h1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    end_cycle();
    p_spur = 0;
    begin_cycle();
    chk("post_rst_no_push", 32'(out_valid), 32'h0);
    end_cycle();

    // Long random run: backpressure, stalls, latencies, redirects, resets
    p_rst = 1; p_redir = 6; p_ready = 70; p_oready = 60; p_spur = 15;
    lat_min = 1; lat_extra = 3; fixed_rpc = 1'b0;
    hold_addr = 32'h0;
    run(4000);

    quiet_knobs();
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
